// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM with fill engine.
package dpram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int unsigned MAX_DW    = 256;
  localparam int unsigned MAX_LANES = MAX_DW / 8;

  function automatic int unsigned lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Replace the bytes of old_word whose enable bit is set with bytes of new_word.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]    old_word,
                                                   input logic [MAX_DW-1:0]    new_word,
                                                   input logic [MAX_LANES-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_fill_fsm.sv
// Fill engine: sweeps every address once with a latched value, after reset or on request.
module dpram_fill_fsm
  import dpram_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 8,
  parameter int unsigned DATAWIDTH     = 8,
  parameter bit          FILL_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fill_req,
  input  logic [DATAWIDTH-1:0] fill_value,
  output logic                 busy,
  output logic                 fill_we,
  output logic [ADDRWIDTH-1:0] fill_addr,
  output logic [DATAWIDTH-1:0] fill_data
);

  localparam int unsigned CW = ADDRWIDTH + 1;

  fill_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATAWIDTH-1:0] val, val_nxt;
  logic                 pend, pend_nxt;
  logic                 busy_nxt;
  logic                 we_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      val     <= '0;
      pend    <= FILL_ON_RESET;
      busy    <= FILL_ON_RESET;
      fill_we <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      val     <= val_nxt;
      pend    <= pend_nxt;
      busy    <= busy_nxt;
      fill_we <= we_nxt;
    end
  end

  // pend holds busy high through the first cycle after reset release until the sweep starts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    val_nxt   = val;
    pend_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pend || fill_req) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
          val_nxt   = fill_value;
        end
      end
      FILL: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt_nxt[ADDRWIDTH]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == FILL);
    we_nxt   = (state_nxt == FILL);
  end

  assign fill_addr = cnt[ADDRWIDTH-1:0];
  assign fill_data = val;

endmodule

// File: rtl/dpram_be_fill.sv
// True dual-port byte-enable RAM with collision rules, optional output register and fill engine.
module dpram_be_fill
  import dpram_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 8,
  parameter int unsigned DATAWIDTH     = 8,
  parameter bit          OUTREG        = 1'b0,
  parameter bit          FILL_ON_RESET = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDRWIDTH-1:0]   address_a,
  input  logic [ADDRWIDTH-1:0]   address_b,
  input  logic [DATAWIDTH-1:0]   data_a,
  input  logic [DATAWIDTH-1:0]   data_b,
  input  logic [DATAWIDTH/8-1:0] byteena_a,
  input  logic [DATAWIDTH/8-1:0] byteena_b,
  input  logic                   wren_a,
  input  logic                   wren_b,
  input  logic                   oe_a_n,
  input  logic                   oe_b_n,
  output logic [DATAWIDTH-1:0]   q_a,
  output logic [DATAWIDTH-1:0]   q_b,
  input  logic                   fill_req,
  input  logic [DATAWIDTH-1:0]   fill_value,
  output logic                   busy
);

  localparam int unsigned LANES = lanes(DATAWIDTH);
  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic                 fill_we;
  logic [ADDRWIDTH-1:0] fill_addr;
  logic [DATAWIDTH-1:0] fill_data;
  logic                 we_a, we_b;
  logic                 a_owns;
  logic [DATAWIDTH-1:0] rd_a, rd_b;
  logic [DATAWIDTH-1:0] out_a, out_b;

  dpram_fill_fsm #(
    .ADDRWIDTH     (ADDRWIDTH),
    .DATAWIDTH     (DATAWIDTH),
    .FILL_ON_RESET (FILL_ON_RESET)
  ) u_fill (
    .clock      (clock),
    .reset_n    (reset_n),
    .fill_req   (fill_req),
    .fill_value (fill_value),
    .busy       (busy),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

  assign we_a   = wren_a & ~busy;
  assign we_b   = wren_b & ~busy;
  assign a_owns = we_a & (address_a == address_b);

  // Array write: fill owns every lane; otherwise port A beats port B lane-by-lane on a shared address
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (fill_we) begin
        mem[fill_addr][8*i +: 8] <= fill_data[8*i +: 8];
      end else begin
        if (we_a && byteena_a[i])
          mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
        if (we_b && byteena_b[i] && !(a_owns && byteena_a[i]))
          mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
      end
    end
  end

  // Own-port writes are visible immediately; the other port always sees the pre-write word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= we_a ? DATAWIDTH'(byte_merge(MAX_DW'(mem[address_a]), MAX_DW'(data_a),
                                           MAX_LANES'(byteena_a)))
                   : mem[address_a];
      rd_b <= we_b ? DATAWIDTH'(byte_merge(MAX_DW'(mem[address_b]), MAX_DW'(data_b),
                                           MAX_LANES'(byteena_b)))
                   : mem[address_b];
    end
  end

  generate
    if (OUTREG) begin : g_outreg
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_a <= '0;
          out_b <= '0;
        end else begin
          out_a <= rd_a;
          out_b <= rd_b;
        end
      end
    end else begin : g_direct
      assign out_a = rd_a;
      assign out_b = rd_b;
    end
  endgenerate

  assign q_a = (oe_a_n | busy) ? '1 : out_a;
  assign q_b = (oe_b_n | busy) ? '1 : out_b;

endmodule

// File: tb/tb_dpram_be_fill.sv
// Bench for dpram_be_fill: latency-1 and latency-2 instances checked against a behavioural model.
module tb_dpram_be_fill;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic [1:0]    be_a, be_b;
  logic          wren_a, wren_b;
  logic          oe_a_n, oe_b_n;
  logic          fill_req;
  logic [DW-1:0] fill_value;
  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
  logic          busy0, busy1;

  int n_assert;
  int n_fail;

  // behavioural model state
  logic [DW-1:0] mm [DEPTH];
  bit            mk [DEPTH];
  bit            m_pend;
  int            fill_left;
  logic [DW-1:0] m_fval;
  bit            m_busy;
  logic [DW-1:0] ra1, rb1, ra2, rb2;
  bit            ka1, kb1, ka2, kb2;

  dpram_be_fill #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .OUTREG(1'b0), .FILL_ON_RESET(1'b1)) u_lat1 (
    .clock(clk), .reset_n(rst_n),
    .address_a(addr_a), .address_b(addr_b), .data_a(data_a), .data_b(data_b),
    .byteena_a(be_a), .byteena_b(be_b), .wren_a(wren_a), .wren_b(wren_b),
    .oe_a_n(oe_a_n), .oe_b_n(oe_b_n), .q_a(q_a0), .q_b(q_b0),
    .fill_req(fill_req), .fill_value(fill_value), .busy(busy0)
  );

  dpram_be_fill #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .OUTREG(1'b1), .FILL_ON_RESET(1'b1)) u_lat2 (
    .clock(clk), .reset_n(rst_n),
    .address_a(addr_a), .address_b(addr_b), .data_a(data_a), .data_b(data_b),
    .byteena_a(be_a), .byteena_b(be_b), .wren_a(wren_a), .wren_b(wren_b),
    .oe_a_n(oe_a_n), .oe_b_n(oe_b_n), .q_a(q_a1), .q_b(q_b1),
    .fill_req(fill_req), .fill_value(fill_value), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [DW-1:0] obs, input logic oe_n,
                       input logic [DW-1:0] r, input bit k);
    if (oe_n || m_busy) chk(tag, obs, 16'hFFFF);
    else if (k) chk(tag, obs, r);
  endtask

  task automatic model_reset();
    m_pend    = 1'b1;
    fill_left = 0;
    m_busy    = 1'b1;
    ra1 = '0; rb1 = '0; ra2 = '0; rb2 = '0;
    ka1 = 1'b1; kb1 = 1'b1; ka2 = 1'b1; kb2 = 1'b1;
  endtask

  // One clock edge of the reference: reads see the array before this edge's writes
  task automatic model_edge();
    logic [DW-1:0] na, nb;
    bit kna, knb, was_busy;
    was_busy = m_busy;
    na = mm[addr_a]; kna = mk[addr_a];
    nb = mm[addr_b]; knb = mk[addr_b];
    if (!was_busy && wren_a) begin na = lane_merge(na, data_a, be_a); kna = kna | (be_a == 2'b11); end
    if (!was_busy && wren_b) begin nb = lane_merge(nb, data_b, be_b); knb = knb | (be_b == 2'b11); end
    ra2 = ra1; ka2 = ka1; rb2 = rb1; kb2 = kb1;
    ra1 = na;  ka1 = kna; rb1 = nb;  kb1 = knb;
    if (m_pend) begin
      m_pend = 1'b0; fill_left = DEPTH; m_fval = fill_value;
    end else if (fill_left > 0) begin
      mm[DEPTH - fill_left] = m_fval;
      mk[DEPTH - fill_left] = 1'b1;
      fill_left--;
    end else begin
      if (fill_req) begin fill_left = DEPTH; m_fval = fill_value; end
      // B first, then A on top: A wins its enabled lanes on a shared address
      if (wren_b) begin
        mm[addr_b] = lane_merge(mm[addr_b], data_b, be_b);
        mk[addr_b] = mk[addr_b] | (be_b == 2'b11);
      end
      if (wren_a) begin
        mm[addr_a] = lane_merge(mm[addr_a], data_a, be_a);
        mk[addr_a] = mk[addr_a] | (be_a == 2'b11);
      end
    end
    m_busy = m_pend || (fill_left > 0);
  endtask

  task automatic check_all();
    chk("busy_lat1", DW'(busy0), DW'(m_busy));
    chk("busy_lat2", DW'(busy1), DW'(m_busy));
    chk_q("q_a_lat1", q_a0, oe_a_n, ra1, ka1);
    chk_q("q_b_lat1", q_b0, oe_b_n, rb1, kb1);
    chk_q("q_a_lat2", q_a1, oe_a_n, ra2, ka2);
    chk_q("q_b_lat2", q_b1, oe_b_n, rb2, kb2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!busy0) break;
    end
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    addr_a = a; addr_b = a; wren_a = 1'b0; wren_b = 1'b0;
    tick();
    chk({tag, "_a_lat1"}, q_a0, e);
    chk({tag, "_b_lat1"}, q_b0, e);
    tick();
    chk({tag, "_a_lat2"}, q_a1, e);
    chk({tag, "_b_lat2"}, q_b1, e);
  endtask

  initial begin
    int n;
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = 1'b0; end
    model_reset();
    m_fval = '0;
    rst_n = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    be_a = 2'b11; be_b = 2'b11; wren_a = 1'b0; wren_b = 1'b0;
    oe_a_n = 1'b0; oe_b_n = 1'b0; fill_req = 1'b0; fill_value = 16'hA5A5;

    // reset: busy high, outputs forced
    tick();
    tick();
    chk("rst_busy", DW'(busy0), 16'h0001);
    chk("rst_q_a", q_a0, 16'hFFFF);

    // power-up fill
    rst_n = 1'b1;
    wait_idle(n);
    chk("fill_cycles_por", DW'(n), 16'd17);
    for (int a = 0; a < DEPTH; a++) rd_check("por_fill", AW'(a), 16'hA5A5);

    // byte-lane merge and same-port new-data read
    addr_a = 4'd2; data_a = 16'h3344; be_a = 2'b11; wren_a = 1'b1;
    tick();
    data_a = 16'hCCDD; be_a = 2'b01;
    tick();
    chk("rdw_same_port", q_a0, 16'h33DD);
    be_a = 2'b11;
    rd_check("be_merge", 4'd2, 16'h33DD);

    // same-address collision, full enables then split lanes
    addr_a = 4'd5; addr_b = 4'd5; data_a = 16'h1212; data_b = 16'h3434;
    be_a = 2'b11; be_b = 2'b11; wren_a = 1'b1; wren_b = 1'b1;
    tick();
    rd_check("coll_full", 4'd5, 16'h1212);
    addr_a = 4'd5; addr_b = 4'd5; be_a = 2'b01; be_b = 2'b10; wren_a = 1'b1; wren_b = 1'b1;
    tick();
    be_a = 2'b11; be_b = 2'b11;
    rd_check("coll_lane", 4'd5, 16'h3412);

    // mixed-port read-during-write returns the old word
    addr_a = 4'd7; data_a = 16'h0000; wren_a = 1'b1;
    tick();
    addr_a = 4'd7; addr_b = 4'd7; data_a = 16'h9999; wren_a = 1'b1; wren_b = 1'b0;
    tick();
    chk("mixed_old_b", q_b0, 16'h0000);
    chk("mixed_new_a", q_a0, 16'h9999);
    wren_a = 1'b0;
    tick();
    chk("mixed_after_b", q_b0, 16'h9999);

    // requested fill ignores user writes and forces q
    fill_value = 16'h5A5A; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    chk("req_busy", DW'(busy0), 16'h0001);
    chk("busy_force_q", q_a0, 16'hFFFF);
    addr_a = 4'd3; data_a = 16'hFFFF; be_a = 2'b11; wren_a = 1'b1;
    wait_idle(n);
    chk("fill_cycles_req", DW'(n), 16'd16);
    rd_check("fill_ignores_wr", 4'd3, 16'h5A5A);

    // reset mid-fill restarts the sweep from address 0
    fill_value = 16'h0F0F; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    oe_a_n = 1'b1;
    rst_n = 1'b1;
    wait_idle(n);
    chk("fill_cycles_restart", DW'(n), 16'd17);
    addr_a = 4'd9;
    tick();
    chk("oe_force", q_a0, 16'hFFFF);
    oe_a_n = 1'b0;
    rd_check("refill", 4'd0, 16'h0F0F);
    rd_check("refill", 4'd9, 16'h0F0F);

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      addr_a     = AW'($urandom_range(0, DEPTH - 1));
      addr_b     = AW'($urandom_range(0, DEPTH - 1));
      data_a     = DW'($urandom);
      data_b     = DW'($urandom);
      be_a       = 2'($urandom_range(0, 3));
      be_b       = 2'($urandom_range(0, 3));
      wren_a     = 1'($urandom_range(0, 1));
      wren_b     = 1'($urandom_range(0, 1));
      oe_a_n     = ($urandom_range(0, 7) == 0);
      oe_b_n     = ($urandom_range(0, 7) == 0);
      fill_req   = ($urandom_range(0, 49) == 0);
      fill_value = DW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
